// File: rtl/avr_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing the AVR serial TX channel among NUM_REQ sources.
// Define AVR_TX_ID_HEADER_EN to prefix every packet with a source-ID byte (8'hF0 | index).
module avr_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ-1:0]     grant,
  output logic [7:0]             tx_data,
  output logic                   new_tx_data,
  input  logic                   tx_busy,
  output logic                   active
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
`ifdef AVR_TX_ID_HEADER_EN
    , HDR = 2'd3
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 new_tx_data_q, new_tx_data_d;
  logic                 active_q, active_d;
  logic                 last_q, last_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;

  logic [7:0]           data_arr [NUM_REQ];
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic                 issue;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) return '0;
    return idx + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) data_arr[i] = req_data[8*i +: 8];
  end

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    logic [IDX_W-1:0] k;
    pick_found = 1'b0;
    pick_idx   = '0;
    k          = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!pick_found && req_valid[k]) begin
        pick_found = 1'b1;
        pick_idx   = k;
      end
    end
  end

  assign issue = !tx_busy && req_valid[owner_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      req_ack_q     <= '0;
      tx_data_q     <= 8'h00;
      new_tx_data_q <= 1'b0;
      active_q      <= 1'b0;
      last_q        <= 1'b0;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      req_ack_q     <= req_ack_d;
      tx_data_q     <= tx_data_d;
      new_tx_data_q <= new_tx_data_d;
      active_q      <= active_d;
      last_q        <= last_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
`ifdef AVR_TX_ID_HEADER_EN
          state_d = HDR;
`else
          state_d = SEND;
`endif
        end
      end
`ifdef AVR_TX_ID_HEADER_EN
      HDR:  if (!tx_busy) state_d = GAP;
`endif
      SEND: if (issue) state_d = GAP;
      GAP:  state_d = last_q ? IDLE : SEND;
      default: state_d = IDLE;
    endcase
  end

  // Strobe and ack default low so each is a single-cycle pulse
  always_comb begin
    grant_d       = grant_q;
    active_d      = active_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    last_d        = last_q;
    tx_data_d     = tx_data_q;
    new_tx_data_d = 1'b0;
    req_ack_d     = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d  = pick_idx;
          grant_d  = onehot(pick_idx);
          active_d = 1'b1;
        end
      end
`ifdef AVR_TX_ID_HEADER_EN
      HDR: begin
        if (!tx_busy) begin
          new_tx_data_d = 1'b1;
          tx_data_d     = 8'hF0 | 8'(owner_q);
          last_d        = 1'b0;
        end
      end
`endif
      SEND: begin
        if (issue) begin
          new_tx_data_d = 1'b1;
          tx_data_d     = data_arr[owner_q];
          req_ack_d     = onehot(owner_q);
          last_d        = req_last[owner_q];
        end
      end
      GAP: begin
        if (last_q) begin
          grant_d  = '0;
          active_d = 1'b0;
          rr_ptr_d = next_idx(owner_q);
        end
      end
      default: ;
    endcase
  end

  assign grant       = grant_q;
  assign req_ack     = req_ack_q;
  assign tx_data     = tx_data_q;
  assign new_tx_data = new_tx_data_q;
  assign active      = active_q;

endmodule
